delay_line_prog: RTL and testbench

- Runtime-programmable circular-buffer delay line for the OFDM datapath (cyclic-prefix insertion/removal, correlator alignment).
- Generalises the fixed power-of-two delay: delay length is loadable at run time from 1 to D enabled samples.
- Adds an output-valid flag that tracks buffer fill, plus a synchronous flush.
- Storage is never cleared. Output is gated to zero until the line holds enough valid samples.

---
 rtl/ofdm_pkg.sv | 16 +
 rtl/delay_ram.sv | 32 +++
 rtl/delay_line_prog.sv | 93 +++++++++
 tb/tb_delay_line_prog.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared constants for the OFDM datapath: sample width, delay-line depth
// defaults and the cyclic-prefix / symbol lengths used as dly_len codes
// (a dly_len code is the wanted delay minus one).
package ofdm_pkg;

   localparam int SAMPLE_W = 32;   // complex sample, 16b I + 16b Q
   localparam int DLY_D    = 64;   // delay-line depth, power of two
   localparam int DLY_B    = 6;    // log2(DLY_D)

   // dly_len codes for common OFDM alignments
   localparam logic [DLY_B-1:0] CP_LEN_4   = 6'd3;
   localparam logic [DLY_B-1:0] CP_LEN_8   = 6'd7;
   localparam logic [DLY_B-1:0] CP_LEN_16  = 6'd15;
   localparam logic [DLY_B-1:0] SYM_LEN_64 = 6'd63;

endpackage

// File: rtl/delay_ram.sv
// Purpose  : WIDTH x D sample store, synchronous write, asynchronous read, no reset.
// Latency  : write visible from the cycle after the edge; read is combinational.
// Backpress: none, one write per cycle when we_i is high.
// Ports    : clk; we_i/wr_adr_i/wr_dat_i write port; rd_adr_i/rd_dat_o read port.
module delay_ram
   import ofdm_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int D     = DLY_D,
   parameter int B     = DLY_B
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [B-1:0]     wr_adr_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic [B-1:0]     rd_adr_i,
   output logic [WIDTH-1:0] rd_dat_o
);

   logic [WIDTH-1:0] mem_q [D];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_adr_i] <= wr_dat_i;
      end
   end

   // Read sees the pre-edge contents, so reading the slot being written
   // this cycle returns the old (oldest) sample.
   assign rd_dat_o = mem_q[rd_adr_i];

endmodule

// File: rtl/delay_line_prog.sv
// Purpose  : runtime-programmable delay line, delay L = dly_len+1 in 1..D enabled samples.
// Latency  : dat_out shows the sample written L enabled samples earlier; ena=0 cycles hold the line.
// Backpress: none; full-rate in/out, output gated to zero until L valid samples are held.
// Ports    : clk, rst (async high); ena sample strobe; clr flush; ld/dly_len length load;
//            dat_in sample in; dat_out/out_vld delayed sample; fill_cnt valid samples held (sat. D).
module delay_line_prog
   import ofdm_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int D     = DLY_D,    // must be a power of two
   parameter int B     = DLY_B     // log2(D)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clr,
   input  logic             ld,
   input  logic [B-1:0]     dly_len,
   input  logic [WIDTH-1:0] dat_in,
   output logic [WIDTH-1:0] dat_out,
   output logic             out_vld,
   output logic [B:0]       fill_cnt
);

   localparam logic [B:0] FILL_MAX = (B+1)'(D);

   logic [B-1:0]     wr_ptr_q, wr_ptr_d;
   logic [B-1:0]     len_q, len_d;
   logic [B:0]       fill_q, fill_d;
   logic [B-1:0]     rd_adr;
   logic             we;
   logic [WIDTH-1:0] ram_dat;

   // A flush suppresses the write so the sample presented with clr is dropped.
   assign we = ena & ~clr;

   // Oldest wanted sample sits L slots behind the write pointer; B-bit wrap
   // makes L=D land on wr_ptr itself (read-before-write of the oldest slot).
   assign rd_adr = wr_ptr_q - len_q - B'(1);

   assign out_vld  = (fill_q >= ({1'b0, len_q} + (B+1)'(1)));
   assign dat_out  = out_vld ? ram_dat : '0;
   assign fill_cnt = fill_q;

   delay_ram #(
      .WIDTH (WIDTH),
      .D     (D),
      .B     (B)
   ) u_ram (
      .clk      (clk),
      .we_i     (we),
      .wr_adr_i (wr_ptr_q),
      .wr_dat_i (dat_in),
      .rd_adr_i (rd_adr),
      .rd_dat_o (ram_dat)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      len_d    = ld ? dly_len : len_q;

      if (clr) begin
         // Flush wins over ld for the fill state; the length still loads.
         wr_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (ena) begin
            wr_ptr_d = wr_ptr_q + B'(1);
         end
         if (ld) begin
            // Restart the fill so no sample older than the new length's
            // history is ever presented as valid.
            fill_d = ena ? (B+1)'(1) : '0;
         end else if (ena && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + (B+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         len_q    <= B'(D-1);   // delay D after reset
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         len_q    <= len_d;
      end
   end

endmodule

// File: tb/tb_delay_line_prog.sv
module tb_delay_line_prog;
   import ofdm_pkg::*;

   localparam int W  = 32;
   localparam int DD = 64;
   localparam int BB = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic          clr;
   logic          ld;
   logic [BB-1:0] dly_len;
   logic [W-1:0]  dat_in;
   logic [W-1:0]  dat_out;
   logic          out_vld;
   logic [BB:0]   fill_cnt;

   delay_line_prog #(.WIDTH(W), .D(DD), .B(BB)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .clr      (clr),
      .ld       (ld),
      .dly_len  (dly_len),
      .dat_in   (dat_in),
      .dat_out  (dat_out),
      .out_vld  (out_vld),
      .fill_cnt (fill_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model: samples written since the last reset/flush/load, and current delay.
   logic [W-1:0] hist[$];
   int           mdl_len;

   // Outputs sampled in the last cycle
   logic         o_vld;
   logic [W-1:0] o_dat;
   logic [BB:0]  o_fill;

   typedef struct {
      logic         e;
      logic         l;
      logic [W-1:0] d;
      logic         ev;
      logic [W-1:0] ed;
      logic [BB:0]  ef;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(input int e, input int l, input int d,
                               input int ev, input int ed, input int ef);
      vec_t v;
      v.e  = (e != 0);
      v.l  = (l != 0);
      v.d  = W'(d);
      v.ev = (ev != 0);
      v.ed = W'(ed);
      v.ef = (BB+1)'(ef);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic mdl_reset();
      hist.delete();
      mdl_len = DD;
   endtask

   // Called at posedge+1: drive one cycle, check at the falling edge, then
   // advance the model with the edge and return at the next posedge+1.
   task automatic cyc(input logic e, input logic c, input logic l,
                      input logic [BB-1:0] dl, input logic [W-1:0] d);
      int           sz;
      logic         ev;
      logic [W-1:0] ed;
      ena = e; clr = c; ld = l; dly_len = dl; dat_in = d;
      #4;
      sz = hist.size();
      ev = (sz >= mdl_len);
      ed = ev ? hist[sz - mdl_len] : '0;
      o_vld  = out_vld;
      o_dat  = dat_out;
      o_fill = fill_cnt;
      chk("model_vld",  64'(o_vld),  64'(ev));
      chk("model_dat",  64'(o_dat),  64'(ed));
      chk("model_fill", 64'(o_fill), 64'(sz));
      @(posedge clk);
      if (c) begin
         hist.delete();
         if (l) mdl_len = int'(dl) + 1;
      end else begin
         if (l) begin
            mdl_len = int'(dl) + 1;
            hist.delete();
         end
         if (e) begin
            hist.push_back(d);
            if (hist.size() > DD) void'(hist.pop_front());
         end
      end
      #1;
   endtask

   // Async reset pulse between clock edges, with no edge seeing it.
   task automatic rst_pulse();
      ena = 1'b0; clr = 1'b0; ld = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_vld",  64'(out_vld),  64'd0);
      chk("arst_dat",  64'(dat_out),  64'd0);
      chk("arst_fill", 64'(fill_cnt), 64'd0);
      #1 rst = 1'b0;
      mdl_reset();
      @(posedge clk);
      #1;
   endtask

   // Stream 1..66 from empty with L=D.
   task automatic stream_from_reset(input string tag);
      for (int k = 1; k <= 66; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 6'd0, W'(k));
         if (k == 64) chk({tag, "_vld_before"}, 64'(o_vld), 64'd0);
         if (k == 65) begin
            chk({tag, "_vld_at65"}, 64'(o_vld), 64'd1);
            chk({tag, "_dat_at65"}, 64'(o_dat), 64'd1);
         end
         if (k == 66) chk({tag, "_dat_at66"}, 64'(o_dat), 64'd2);
      end
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; clr = 1'b0; ld = 1'b0; dly_len = '0; dat_in = '0;
      mdl_reset();

      tbl[0]  = mk(1, 1,  1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 11, 0, 0, 1);
      tbl[2]  = mk(1, 0,  2, 0, 0, 1);
      tbl[3]  = mk(0, 0, 12, 0, 0, 2);
      tbl[4]  = mk(1, 0,  3, 0, 0, 2);
      tbl[5]  = mk(0, 0, 13, 0, 0, 3);
      tbl[6]  = mk(1, 0,  4, 0, 0, 3);
      tbl[7]  = mk(0, 0, 14, 1, 1, 4);
      tbl[8]  = mk(1, 0,  5, 1, 1, 4);
      tbl[9]  = mk(0, 0, 15, 1, 2, 5);
      tbl[10] = mk(1, 0,  6, 1, 2, 5);
      tbl[11] = mk(0, 0, 16, 1, 3, 6);
      tbl[12] = mk(1, 0,  7, 1, 3, 6);
      tbl[13] = mk(0, 0, 17, 1, 4, 7);
      tbl[14] = mk(1, 0,  8, 1, 4, 7);
      tbl[15] = mk(0, 0, 18, 1, 5, 8);
      tbl[16] = mk(1, 0,  9, 1, 5, 8);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_vld",  64'(out_vld),  64'd0);
      chk("reset_dat",  64'(dat_out),  64'd0);
      chk("reset_fill", 64'(fill_cnt), 64'd0);
      rst = 1'b0;

      // Delay D from reset
      stream_from_reset("sc1");

      // Load L=16 and stream; fill saturates at D
      for (int k = 1; k <= 70; k++) begin
         cyc(1'b1, 1'b0, (k == 1), CP_LEN_16, W'(k));
         if (k == 16) chk("sc2_vld_16", 64'(o_vld), 64'd0);
         if (k == 17) chk("sc2_vld_17", 64'(o_vld), 64'd1);
         if (k >= 17) chk("sc2_dat", 64'(o_dat), 64'(k - 16));
         if (k == 65 || k == 70) chk("sc2_fill_sat", 64'(o_fill), 64'd64);
      end

      // Toggled ena with L=4, from a flushed line
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 32'd0);
      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].e, 1'b0, tbl[i].l, CP_LEN_4, tbl[i].d);
         chk($sformatf("tbl%0d_vld", i),  64'(o_vld),  64'(tbl[i].ev));
         chk($sformatf("tbl%0d_dat", i),  64'(o_dat),  64'(tbl[i].ed));
         chk($sformatf("tbl%0d_fill", i), 64'(o_fill), 64'(tbl[i].ef));
      end

      // Mid-stream reload from L=16 to L=4
      for (int k = 201; k <= 240; k++) begin
         cyc(1'b1, 1'b0, (k == 201 || k == 231), (k == 201) ? CP_LEN_16 : CP_LEN_4, W'(k));
         if (k == 230) chk("sc4_dat_before", 64'(o_dat), 64'd214);
         if (k == 231) chk("sc4_dat_ldcyc",  64'(o_dat), 64'd215);
         if (k >= 232 && k <= 234) chk("sc4_vld_refill", 64'(o_vld), 64'd0);
         if (k >= 235) begin
            chk("sc4_vld", 64'(o_vld), 64'd1);
            chk("sc4_dat", 64'(o_dat), 64'(k - 4));
         end
      end

      // Flush with ena while presenting 99, L=16
      for (int k = 80; k <= 120; k++) begin
         cyc(1'b1, (k == 99), (k == 80), CP_LEN_16, W'(k));
         if (k == 98)  chk("sc5_vld_pre", 64'(o_vld), 64'd1);
         if (k == 100) chk("sc5_fill_after_clr", 64'(o_fill), 64'd0);
         if (k >= 100 && k <= 115) chk("sc5_vld_refill", 64'(o_vld), 64'd0);
         if (k >= 116) chk("sc5_dat", 64'(o_dat), 64'(k - 16));
      end

      // Async reset mid-stream, then the line restarts as from reset
      rst_pulse();
      stream_from_reset("sc6");

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic         e, c, l;
         logic [BB-1:0] dl;
         e  = ($urandom_range(0, 9) < 7);
         c  = ($urandom_range(0, 49) == 0);
         l  = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 3))
            0:       dl = 6'd0;
            1:       dl = SYM_LEN_64;
            default: dl = BB'($urandom_range(0, DD - 1));
         endcase
         cyc(e, c, l, dl, W'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
